// File: rtl/rvfi_imem_pkg.sv
// ----------------------------------------------------------------------------
// rvfi_imem_pkg
// Shared types for the RVFI instruction-memory consistency tracker:
//   half_t       - one captured instruction halfword
//   slot_state_e - per-slot tracking state (EMPTY / LOCKED)
//   idx_w()      - $clog2 with a floor of 1, for index/count widths
// ----------------------------------------------------------------------------
package rvfi_imem_pkg;

  typedef logic [15:0] half_t;

  typedef enum logic {
    EMPTY  = 1'b0,
    LOCKED = 1'b1
  } slot_state_e;

  // Width needed to hold values 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rvfi_imem_tracker_if.sv
// ----------------------------------------------------------------------------
// rvfi_imem_tracker_if
// RVFI retirement bundle observed by the tracker (NRET channels, packed
// channel-major, channel 0 in the low bits).
//   rvfi_valid     NRET           retirement valid per channel
//   rvfi_insn      NRET*32        retired instruction word
//   rvfi_pre_pc    NRET*XLEN      PC of the retired instruction
//   rvfi_mem_addr  NRET*XLEN      store address (XLEN/8 aligned)
//   rvfi_mem_wmask NRET*XLEN/8    store byte mask
// Modports: master (core / harness side drives), slave (tracker observes).
// ----------------------------------------------------------------------------
interface rvfi_imem_tracker_if #(
  parameter int XLEN = 32,
  parameter int NRET = 1
);

  logic [NRET-1:0]        rvfi_valid;
  logic [NRET*32-1:0]     rvfi_insn;
  logic [NRET*XLEN-1:0]   rvfi_pre_pc;
  logic [NRET*XLEN-1:0]   rvfi_mem_addr;
  logic [NRET*XLEN/8-1:0] rvfi_mem_wmask;

  modport master (
    output rvfi_valid,
    output rvfi_insn,
    output rvfi_pre_pc,
    output rvfi_mem_addr,
    output rvfi_mem_wmask
  );

  modport slave (
    input rvfi_valid,
    input rvfi_insn,
    input rvfi_pre_pc,
    input rvfi_mem_addr,
    input rvfi_mem_wmask
  );

endinterface

// File: rtl/rvfi_imem_slot.sv
// ----------------------------------------------------------------------------
// rvfi_imem_slot
// One tracked halfword address. Walks the retirement channels oldest-first
// in a single cycle: a fetch hit either captures (EMPTY) or compares
// (LOCKED); afterwards that channel's store may release the slot.
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   addr         tracked address (bit 0 ignored)
//   rvfi         retirement bundle (slave modport)
//   valid        slot is LOCKED (registered)
//   data         captured halfword (registered)
//   mismatch     some channel fetched a different halfword this cycle
//   match_cnt    number of matching compares this cycle
// ----------------------------------------------------------------------------
module rvfi_imem_slot
  import rvfi_imem_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NRET      = 1,
  parameter int STORE_INV = 1,
  parameter int MC_W      = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [XLEN-1:0]      addr,
  rvfi_imem_tracker_if.slave   rvfi,
  output logic                 valid,
  output half_t                data,
  output logic                 mismatch,
  output logic [MC_W-1:0]      match_cnt
);

  localparam int MW = XLEN / 8;

  slot_state_e      state;
  slot_state_e      state_n;
  half_t            data_n;
  half_t            hw;
  logic [XLEN-1:0]  base;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  maddr;
  logic [31:0]      insn;
  logic [MW-1:0]    wmask;
  logic             hit;
  logic             overlap;

  assign base  = addr & ~XLEN'(1);
  assign valid = (state == LOCKED);

  // Channels are folded in index order so a younger channel sees the state
  // left behind by older ones; within a channel the fetch goes before the
  // store release.
  always_comb begin
    state_n   = state;
    data_n    = data;
    mismatch  = 1'b0;
    match_cnt = '0;
    pc        = '0;
    maddr     = '0;
    insn      = '0;
    wmask     = '0;
    hw        = '0;
    hit       = 1'b0;
    overlap   = 1'b0;
    for (int c = 0; c < NRET; c++) begin
      if (rvfi.rvfi_valid[c]) begin
        pc    = rvfi.rvfi_pre_pc[c*XLEN +: XLEN];
        insn  = rvfi.rvfi_insn[c*32 +: 32];
        maddr = rvfi.rvfi_mem_addr[c*XLEN +: XLEN];
        wmask = rvfi.rvfi_mem_wmask[c*MW +: MW];

        // Only a 32-bit instruction can supply the halfword at pc+2.
        hit = 1'b0;
        hw  = insn[15:0];
        if (pc == base) begin
          hit = 1'b1;
        end else if ((insn[1:0] == 2'b11) && ((pc + XLEN'(2)) == base)) begin
          hit = 1'b1;
          hw  = insn[31:16];
        end

        if (hit) begin
          if (state_n == EMPTY) begin
            state_n = LOCKED;
            data_n  = hw;
          end else if (hw == data_n) begin
            match_cnt = match_cnt + MC_W'(1);
          end else begin
            mismatch = 1'b1;
          end
        end

        overlap = 1'b0;
        for (int k = 0; k < MW; k++) begin
          if (wmask[k] && (((maddr + XLEN'(k)) & ~XLEN'(1)) == base)) begin
            overlap = 1'b1;
          end
        end
        if ((STORE_INV != 0) && overlap) begin
          state_n = EMPTY;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= EMPTY;
      data  <= '0;
    end else begin
      state <= state_n;
      data  <= data_n;
    end
  end

`ifdef FORMAL
  always_comb cover (state == LOCKED);
`endif

endmodule

// File: rtl/rvfi_imem_tracker.sv
// ----------------------------------------------------------------------------
// rvfi_imem_tracker
// Checks that every fetch from a tracked halfword address returns the value
// first fetched there, unless an overlapping store released it in between.
// Ports:
//   clk, resetn    clock, asynchronous active-low reset
//   slot_addr      NSLOTS*XLEN tracked addresses (bit 0 ignored, held static)
//   rvfi           retirement bundle (slave modport)
//   slot_valid     per-slot captured flag
//   slot_data      per-slot captured halfword (16 bits each)
//   mismatch       sticky inconsistency flag
//   mismatch_slot  slot of the first inconsistency (lowest index on ties)
//   check_cnt      saturating count of matching compares
// ----------------------------------------------------------------------------
module rvfi_imem_tracker
  import rvfi_imem_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NRET      = 1,
  parameter int NSLOTS    = 2,
  parameter int CNT_W     = 16,
  parameter int STORE_INV = 1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NSLOTS*XLEN-1:0]      slot_addr,
  rvfi_imem_tracker_if.slave          rvfi,
  output logic [NSLOTS-1:0]           slot_valid,
  output logic [NSLOTS*16-1:0]        slot_data,
  output logic                        mismatch,
  output logic [idx_w(NSLOTS)-1:0]    mismatch_slot,
  output logic [CNT_W-1:0]            check_cnt
);

  localparam int MSW   = idx_w(NSLOTS);
  localparam int MC_W  = idx_w(NRET + 1);
  localparam int SUM_W = CNT_W + 16;

  logic [NSLOTS-1:0] slot_mm;
  logic [MC_W-1:0]   slot_cnt [NSLOTS];
  logic [MSW-1:0]    first_mm;
  logic [SUM_W-1:0]  cnt_sum;

  for (genvar s = 0; s < NSLOTS; s++) begin : g_slot
    rvfi_imem_slot #(
      .XLEN      (XLEN),
      .NRET      (NRET),
      .STORE_INV (STORE_INV),
      .MC_W      (MC_W)
    ) u_slot (
      .clk       (clk),
      .resetn    (resetn),
      .addr      (slot_addr[s*XLEN +: XLEN]),
      .rvfi      (rvfi),
      .valid     (slot_valid[s]),
      .data      (slot_data[s*16 +: 16]),
      .mismatch  (slot_mm[s]),
      .match_cnt (slot_cnt[s])
    );
  end

  // Scanning downwards leaves the lowest mismatching index in first_mm.
  // The count sum is computed wide so saturation is a simple overflow test.
  always_comb begin
    first_mm = '0;
    for (int s = NSLOTS - 1; s >= 0; s--) begin
      if (slot_mm[s]) begin
        first_mm = MSW'(s);
      end
    end
    cnt_sum = SUM_W'(check_cnt);
    for (int s = 0; s < NSLOTS; s++) begin
      cnt_sum = cnt_sum + SUM_W'(slot_cnt[s]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mismatch      <= 1'b0;
      mismatch_slot <= '0;
      check_cnt     <= '0;
    end else begin
      if (!mismatch && (|slot_mm)) begin
        mismatch      <= 1'b1;
        mismatch_slot <= first_mm;
      end
      if (|cnt_sum[SUM_W-1:CNT_W]) begin
        check_cnt <= '1;
      end else begin
        check_cnt <= cnt_sum[CNT_W-1:0];
      end
    end
  end

`ifdef FORMAL
  always_comb begin
    if (resetn) begin
      assert (slot_mm == '0);
    end
  end
`endif

endmodule

// File: doc/rvfi_imem_tracker.md
# rvfi_imem_tracker

Parametrised RVFI instruction-memory consistency tracker for formal and simulation harnesses. It watches up to `NRET` retirement channels and keeps `NSLOTS` tracked halfword addresses. On the first fetch from a tracked address it captures the halfword. Later fetches from that address must match the captured value; a store that overlaps the halfword releases the capture, so self-modifying code is handled. Unlike the single-address check, it needs no pre-chosen data value and reports through sticky registered outputs as well as assertions.

## Interface
Parameters:
- `XLEN`, 32: register/address width.
- `NRET`, 1: number of retirement channels.
- `NSLOTS`, 2: number of tracked halfword addresses.
- `CNT_W`, 16: width of the check counter.
- `STORE_INV`, 1: 1 = an overlapping store releases the slot; 0 = stores are ignored.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  asynchronous active-low reset.
- `slot_addr`  in  NSLOTS*XLEN  tracked addresses; bit 0 is ignored; the harness holds them constant.
- `rvfi_valid`  in  NRET  retirement valid, per channel.
- `rvfi_insn`  in  NRET*32  retired instruction word.
- `rvfi_pre_pc`  in  NRET*XLEN  PC of the retired instruction.
- `rvfi_mem_addr`  in  NRET*XLEN  store address, XLEN/8-aligned.
- `rvfi_mem_wmask`  in  NRET*XLEN/8  store byte mask.
- `slot_valid`  out  NSLOTS  slot holds a captured halfword.
- `slot_data`  out  NSLOTS*16  captured halfword, per slot.
- `mismatch`  out  1  sticky; set on the first inconsistent fetch.
- `mismatch_slot`  out  $clog2(NSLOTS) (minimum 1)  slot that caused the first mismatch; frozen after the first mismatch.
- `check_cnt`  out  CNT_W  saturating count of compares that matched.

## Operation
- Each slot is a 2-state FSM.
  - EMPTY → LOCKED on a fetch hit: capture the halfword and set `slot_valid`.
  - LOCKED + fetch hit: compare with the captured halfword. Equal: `check_cnt`+1 (saturates at all-ones). Unequal: set `mismatch`, latch `mismatch_slot`; the slot stays LOCKED with its old data.
  - LOCKED + store overlap with `STORE_INV`=1 → EMPTY.
- Fetch hit for channel c and slot address A (bit 0 forced to 0):
  - Hit if `rvfi_pre_pc` == A. The halfword is `insn[15:0]`.
  - Also hit if `insn[1:0]`==2'b11 and `rvfi_pre_pc`+2 == A (mod 2^XLEN). The halfword is `insn[31:16]`.
  - A compressed instruction never supplies an upper halfword.
- Store overlap: some byte k with `wmask[k]`=1 has (`mem_addr`+k) with bit 0 cleared equal to A.
- Channels are processed in index order within a cycle; channel 0 is oldest. A slot state updated by channel i is what channel j>i sees.
- Within one channel, the fetch check precedes that channel's own store invalidation.
- Simultaneous mismatches: the lowest slot index wins `mismatch_slot`.
- Channels with `rvfi_valid`=0 are ignored entirely.
- `ifdef FORMAL`: immediate assert that no mismatch occurs, and a cover on each slot reaching LOCKED.

## Timing
- All state is registered on `posedge clk`. Outputs reflect retirements of the previous edge: one cycle latency.
- Reset (`resetn`=0, asynchronous): all slots EMPTY; `slot_valid`=0, `slot_data`=0, `mismatch`=0, `mismatch_slot`=0, `check_cnt`=0.
- Reset asserted mid-operation clears captures immediately, with no clock needed.
- `mismatch` stays set until reset.
- `check_cnt` holds at 2^CNT_W−1 once saturated.
- Multiple matched compares in one cycle add their total, saturating.

## Structure
- Package `rvfi_imem_pkg`: the halfword type, the slot-state enum (EMPTY, LOCKED), and the `$clog2` helper constant.
- Sub-module `rvfi_imem_slot`:
  - one instance per slot; holds the FSM and captured data;
  - does its own per-channel ordered evaluation;
  - outputs `slot_valid`, `slot_data`, a mismatch flag, and a per-cycle match count.
- Top level: priority-encodes `mismatch_slot`, sums match counts with saturation, and holds the sticky flag.

## Test plan
- NRET=1, slot0=0x100; retire 0x00A00093 at pc 0x100, then again → `slot_valid[0]`=1, `slot_data`=0x0093, `check_cnt`=1, `mismatch`=0.
- Slot1=0x102; 32-bit insn 0x12345003 at pc 0x100 → slot1 captures 0x1234. Later a compressed insn at 0x102 with low halfword 0x4501 → `mismatch`=1, `mismatch_slot`=1.
- Slot0 LOCKED at 0x100; store `mem_addr`=0x100, `wmask`=4'b0010; then a new insn at 0x100 → slot re-captures, `mismatch`=0. Repeat with `STORE_INV`=0 → `mismatch`=1.
- NRET=2, same cycle:
  - channel 0 stores `wmask`=4'b0001 to 0x100 while channel 1 fetches a different halfword at 0x100 → no mismatch, new capture;
  - channels swapped (channel 0 fetches, channel 1 stores) → mismatch.
- `CNT_W`=2: five matching fetches → `check_cnt`=3.
- Pull `resetn` low between clock edges while locked with `mismatch`=1 → all outputs 0 immediately.
